// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard decoder: prefix bytes,
// ignored codes, ps2_key field positions and the frame receiver states.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE  = 8'hE1;
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Keyboard status/ack bytes that never describe a key.
  function automatic logic ps2_is_ignored(input logic [7:0] code);
    case (code)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Keyboard-facing bundle: raw PS/2 lines in, decoded key event word out.
interface ps2_key_decoder_if;

  logic        ps2_kbd_clk;
  logic        ps2_kbd_data;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  // master drives the PS/2 lines (keyboard / bench), slave is the decoder
  modport master (
    output ps2_kbd_clk,
    output ps2_kbd_data,
    input  ps2_key,
    input  key_strobe,
    input  frame_err
  );

  modport slave (
    input  ps2_kbd_clk,
    input  ps2_kbd_data,
    output ps2_key,
    output key_strobe,
    output frame_err
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 byte deframer: synchronizes and debounces clk/data, runs the
// start/data/parity/stop FSM on falling clock edges, with a partial-frame watchdog.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 24000
) (
  input  logic       clk_sys,
  input  logic       RESET,
  input  logic       ps2_clk_raw,
  input  logic       ps2_data_raw,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [1:0] raw;
  logic [1:0] filt;
  assign raw = {ps2_data_raw, ps2_clk_raw};

  // index 0 = clock line, index 1 = data line
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic       s1_q, s2_q, filt_q, filt_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (s2_q != filt_q) begin
        if (cnt_q == 8'(FILTER_LEN - 1)) filt_d = s2_q;
        else                             cnt_d  = cnt_q + 8'd1;
      end
    end

    always_ff @(posedge clk_sys) begin
      if (RESET) begin
        s1_q   <= 1'b1;
        s2_q   <= 1'b1;
        filt_q <= 1'b1;
        cnt_q  <= '0;
      end else begin
        s1_q   <= raw[gi];
        s2_q   <= s1_q;
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    assign filt[gi] = filt_q;
  end

  rx_state_e       state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_ok_q, par_ok_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            clk_prev_q;
  logic            fall;
  logic            data;

  assign fall = clk_prev_q & ~filt[0];
  assign data = filt[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    wd_d      = wd_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      // an edge always beats a coincident timeout
      wd_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!data) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d   = {data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = ^{shift_q, data};
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          if (data && par_ok_q) valid_d = 1'b1;
          else                  err_d   = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_IDLE) begin
      wd_d = '0;
    end else if (wd_q >= WD_W'(TIMEOUT)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      wd_d    = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_ok_q   <= 1'b0;
      wd_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      wd_q       <= wd_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      clk_prev_q <= filt[0];
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard decoder: turns deframed bytes into toggle-style
// {toggle, pressed, extended, code} events, resolving E0/F0 prefixes and swallowing Pause.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 24000
) (
  input  logic              clk_sys,
  input  logic              RESET,
  ps2_key_decoder_if.slave  kbd
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_frame_rx (
    .clk_sys      (clk_sys),
    .RESET        (RESET),
    .ps2_clk_raw  (kbd.ps2_kbd_clk),
    .ps2_data_raw (kbd.ps2_kbd_data),
    .rx_byte      (rx_byte),
    .byte_valid   (rx_valid),
    .frame_err    (rx_err)
  );

  logic [10:0] key_q, key_d;
  logic        strobe_q, strobe_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [2:0]  skip_q, skip_d;

  always_comb begin
    key_d    = key_q;
    strobe_d = 1'b0;
    ext_d    = ext_q;
    brk_d    = brk_q;
    skip_d   = skip_q;
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (rx_byte == PS2_PFX_PAUSE) begin
        skip_d = PS2_PAUSE_SKIP;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end else if (rx_byte == PS2_PFX_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_PFX_BRK) begin
        brk_d = 1'b1;
      end else if (ps2_is_ignored(rx_byte)) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
        key_d[KEY_PRESSED] = ~brk_q;
        key_d[KEY_EXT]     = ext_q;
        key_d[7:0]         = rx_byte;
        strobe_d           = 1'b1;
        ext_d              = 1'b0;
        brk_d              = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      key_q    <= '0;
      strobe_q <= 1'b0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_q   <= '0;
    end else begin
      key_q    <= key_d;
      strobe_q <= strobe_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      skip_q   <= skip_d;
    end
  end

  assign kbd.ps2_key    = key_q;
  assign kbd.key_strobe = strobe_q;
  assign kbd.frame_err  = rx_err;

endmodule
